// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the controller's DECODE step.
// Issues a BRAM read for the requested PC, waits out the read latency,
// captures the returned word and pulses fetch_done with it. Also flags the
// program-end (halt) opcode.
// Optional feature macro: FETCH_PERF_EN (saturating completed-fetch counter).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for fetch_req
// ISSUE   | first read cycle; mem_en/mem_ren/mem_addr driven
// WAIT    | remaining read cycles; counter walks down to 1
// CAPTURE | instr_out/pc_out/halt valid, fetch_done pulsed
//
// mem_dout is taken on the READ_LAT-th cycle that mem_ren is high (the last
// ISSUE/WAIT cycle), so instr_out is already valid during the fetch_done cycle.
module fetch_unit #(
  parameter int          ADDR_W      = 16,
  parameter int          READ_LAT    = 3,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus1,
  output logic              fetch_done,
  output logic              busy,
  output logic              halt,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_lat_q, pc_lat_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] instr_q, pc_out_q, pc_plus1_q;
  logic        halt_q;
  logic        capture_en;

  // State, latched PC and wait counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_lat_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_lat_q <= pc_lat_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state logic; flush wins over completion while the read is in flight
  always_comb begin
    state_d    = state_q;
    pc_lat_d   = pc_lat_q;
    wait_d     = wait_q;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_req && !flush) begin
          pc_lat_d = pc_in;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (READ_LAT == 1) begin
          state_d    = S_CAPTURE;
          capture_en = 1'b1;
        end else begin
          wait_d  = 4'(READ_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (wait_q == 4'd1) begin
          state_d    = S_CAPTURE;
          capture_en = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction register and companions, loaded on the last read cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus1_q <= '0;
      halt_q     <= 1'b0;
    end else if (capture_en) begin
      instr_q    <= mem_dout;
      pc_out_q   <= pc_lat_q;
      pc_plus1_q <= pc_lat_q + 32'd1;
      halt_q     <= (mem_dout[31:26] == HALT_OPCODE);
    end
  end

  assign mem_en     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mem_ren    = mem_en;
  assign mem_addr   = pc_lat_q[ADDR_W-1:0];
  assign instr_out  = instr_q;
  assign pc_out     = pc_out_q;
  assign pc_plus1   = pc_plus1_q;
  assign halt       = halt_q;
  assign fetch_done = (state_q == S_CAPTURE);
  assign busy       = (state_q != S_IDLE);

`ifdef FETCH_PERF_EN
  logic [31:0] count_q, count_d;

  // Saturating count of completed fetches
  always_comb begin
    count_d = count_q;
    if (fetch_done && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Completed-fetch counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default READ_LAT=3 instance plus a
// READ_LAT=1 instance. Inputs are driven and outputs sampled on negedges.
module tb_fetch_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, flush;
  logic [31:0] pc_in;
  logic [31:0] mem_dout;
  logic        mem_en, mem_ren;
  logic [15:0] mem_addr;
  logic [31:0] instr_out, pc_out, pc_plus1, fetch_count;
  logic        fetch_done, busy, halt;

  logic        req1;
  logic [31:0] pc1;
  logic [31:0] mem_dout1;
  logic        en1, ren1, done1, busy1, halt1;
  logic [15:0] addr1;
  logic [31:0] instr1, pco1, pcp1, cnt1;

  logic [31:0] rdata, rdata1;
  int          ren_cnt, ren_cnt1;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .READ_LAT(LAT), .HALT_OPCODE(6'b111111)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .pc_in(pc_in),
    .flush(flush), .mem_en(mem_en), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus1(pc_plus1), .fetch_done(fetch_done), .busy(busy), .halt(halt),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.ADDR_W(16), .READ_LAT(1), .HALT_OPCODE(6'b111111)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req1), .pc_in(pc1),
    .flush(1'b0), .mem_en(en1), .mem_ren(ren1), .mem_addr(addr1),
    .mem_dout(mem_dout1), .instr_out(instr1), .pc_out(pco1),
    .pc_plus1(pcp1), .fetch_done(done1), .busy(busy1), .halt(halt1),
    .fetch_count(cnt1)
  );

  // BRAM model: data valid only on the LAT-th consecutive cycle of mem_ren
  always @(posedge clk) begin
    ren_cnt  <= mem_ren ? ren_cnt + 1 : 0;
    ren_cnt1 <= ren1 ? ren_cnt1 + 1 : 0;
  end
  assign mem_dout  = (mem_ren && ren_cnt == LAT - 1) ? rdata : 32'hDEAD_BEEF;
  assign mem_dout1 = (ren1 && ren_cnt1 == 0) ? rdata1 : 32'hDEAD_BEEF;

  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                           output int lat, output logic [15:0] addr_seen,
                           output logic ren_seen);
    rdata = data;
    @(negedge clk);
    fetch_req = 1'b1;
    pc_in     = pc;
    @(negedge clk);
    fetch_req = 1'b0;
    addr_seen = mem_addr;
    ren_seen  = mem_en & mem_ren;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (fetch_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_req = 1'b0; flush = 1'b0; pc_in = '0;
    req1 = 1'b0; pc1 = '0; rdata = '0; rdata1 = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_ren, fetch_done, busy, halt} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_ren, fetch_done, busy, halt});
    else pass_cnt++;
    total_cnt++;
    if ({instr_out, pc_out, pc_plus1, fetch_count, mem_addr} !== 144'd0)
      $display("FAIL reset_data: instr=%h pc=%h pc1=%h cnt=%h addr=%h", instr_out, pc_out, pc_plus1, fetch_count, mem_addr);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] a; logic r;
    run_fetch(32'h5, 32'h8C22_0004, lat, a, r);
    total_cnt++;
    if (a !== 16'h0005 || r !== 1'b1) $display("FAIL basic_issue: addr=%h ren=%b want 0005/1", a, r);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (instr_out !== 32'h8C22_0004 || pc_out !== 32'h5 || pc_plus1 !== 32'h6 || halt !== 1'b0)
      $display("FAIL basic_capture: instr=%h pc=%h pc1=%h halt=%b", instr_out, pc_out, pc_plus1, halt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (fetch_done !== 1'b0 || busy !== 1'b0 || mem_ren !== 1'b0)
      $display("FAIL basic_pulse: done=%b busy=%b ren=%b want 000", fetch_done, busy, mem_ren);
    else pass_cnt++;
  endtask

  task automatic test_halt_back_to_back();
    int lat; logic [15:0] a; logic r;
    run_fetch(32'h8, 32'hFC00_0000, lat, a, r);
    total_cnt++;
    if (halt !== 1'b1 || lat !== 4) $display("FAIL halt_set: halt=%b lat=%0d want 1/4", halt, lat);
    else pass_cnt++;
    run_fetch(32'h9, 32'h0000_0020, lat, a, r);
    total_cnt++;
    if (halt !== 1'b0 || lat !== 4 || instr_out !== 32'h0000_0020)
      $display("FAIL halt_clear: halt=%b lat=%0d instr=%h want 0/4/00000020", halt, lat, instr_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int ndone = 0; int lat; logic [15:0] a; logic r;
    rdata = 32'h1234_5678;
    @(negedge clk); fetch_req = 1'b1; pc_in = 32'h10;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    total_cnt++;
    if (mem_ren !== 1'b0 || fetch_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_drop: ren=%b done=%b busy=%b want 000", mem_ren, fetch_done, busy);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      if (fetch_done) ndone++;
      @(negedge clk);
    end
    total_cnt++;
    if (ndone !== 0 || instr_out !== 32'h0000_0020 || pc_out !== 32'h9)
      $display("FAIL flush_hold: dones=%0d instr=%h pc=%h want 0/00000020/9", ndone, instr_out, pc_out);
    else pass_cnt++;
    run_fetch(32'h20, 32'hAABB_CCDD, lat, a, r);
    total_cnt++;
    if (lat !== 4 || instr_out !== 32'hAABB_CCDD || pc_out !== 32'h20 || a !== 16'h0020)
      $display("FAIL flush_next: lat=%0d instr=%h pc=%h addr=%h", lat, instr_out, pc_out, a);
    else pass_cnt++;
  endtask

  task automatic test_pc_bounds();
    int lat; logic [15:0] a; logic r;
    run_fetch(32'hFFFF_FFFF, 32'h0101_0101, lat, a, r);
    total_cnt++;
    if (a !== 16'hFFFF || pc_plus1 !== 32'h0 || pc_out !== 32'hFFFF_FFFF)
      $display("FAIL pc_wrap: addr=%h pc1=%h pc=%h want FFFF/00000000/FFFFFFFF", a, pc_plus1, pc_out);
    else pass_cnt++;
    run_fetch(32'h0001_2345, 32'h0202_0202, lat, a, r);
    total_cnt++;
    if (a !== 16'h2345 || pc_plus1 !== 32'h0001_2346)
      $display("FAIL pc_trunc: addr=%h pc1=%h want 2345/00012346", a, pc_plus1);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    int ndone = 0;
    rdata = 32'h1111_1111;
    @(negedge clk); fetch_req = 1'b1; pc_in = 32'h40;
    @(negedge clk); fetch_req = 1'b0; pc_in = 32'h99;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    if (fetch_done) ndone++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fetch_done) ndone++;
    end
    total_cnt++;
    if (ndone !== 1 || instr_out !== 32'h1111_1111 || pc_out !== 32'h40)
      $display("FAIL busy_ignore: dones=%0d instr=%h pc=%h want 1/11111111/40", ndone, instr_out, pc_out);
    else pass_cnt++;
    ndone = 0;
    fetch_req = 1'b1; flush = 1'b1; pc_in = 32'h55;
    @(negedge clk); fetch_req = 1'b0; flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (fetch_done || busy) ndone++;
      @(negedge clk);
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL idle_flush_req: busy/done cycles=%0d want 0", ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    rdata = 32'h7777_7777;
    @(negedge clk); fetch_req = 1'b1; pc_in = 32'h77;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_en, mem_ren, fetch_done, busy, halt} !== 5'b0 ||
        {instr_out, pc_out, pc_plus1, fetch_count, mem_addr} !== 144'd0)
      $display("FAIL reset_async: ctl=%b instr=%h pc=%h pc1=%h cnt=%h addr=%h",
               {mem_en, mem_ren, fetch_done, busy, halt}, instr_out, pc_out, pc_plus1, fetch_count, mem_addr);
    else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (fetch_done || busy) ndone++;
      @(negedge clk);
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL reset_release: busy/done cycles=%0d want 0", ndone);
    else pass_cnt++;
  endtask

  task automatic test_perf_count();
    int lat; logic [15:0] a; logic r;
    logic [31:0] exp_cnt;
    for (int i = 0; i < 5; i++) run_fetch(32'h100 + i, 32'h0 + i, lat, a, r);
    @(negedge clk); fetch_req = 1'b1; pc_in = 32'h200;
    @(negedge clk); fetch_req = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (4) @(negedge clk);
`ifdef FETCH_PERF_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    total_cnt++;
    if (fetch_count !== exp_cnt) $display("FAIL perf_count: got %0d want %0d", fetch_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read_lat1();
    int lat = -1;
    rdata1 = 32'hCAFE_0001;
    @(negedge clk); req1 = 1'b1; pc1 = 32'h33;
    @(negedge clk); req1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (done1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (lat !== 2 || instr1 !== 32'hCAFE_0001 || pco1 !== 32'h33 || addr1 !== 16'h0033)
      $display("FAIL lat1_fetch: lat=%0d instr=%h pc=%h addr=%h want 2/CAFE0001/33/0033", lat, instr1, pco1, addr1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt_back_to_back();
    test_flush();
    test_pc_bounds();
    test_ignore();
    test_reset_mid();
    test_perf_count();
    test_read_lat1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
